// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// ALU/PC mux codes and the bundled control-word struct.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ILLEGAL = 4'd11
  } state_t;

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // ALU B-operand select: register B, constant 4, sign-ext imm, imm << 2
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Per-state control-word decode. Depends only on state and MemReady, never on
// the opcode. JUMP outputs exist only when MIPS_CTRL_JUMP_EN is defined.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        // IR and PC latch only in the cycle the fetch data actually arrives
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCS_JUMP;
        ctrl.instr_done = 1'b1;
      end
`endif
      S_ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: state register and next-state logic; outputs
// come from mips_ctrl_outdec. Define MIPS_CTRL_JUMP_EN to support j (opcode 2).
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] State,
  output logic       InstrDone,
  output logic       IllegalOp
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_R:          state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
`ifdef MIPS_CTRL_JUMP_EN
          OP_J:          state_d = S_JUMP;
`endif
          default:       state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_MEMWB, S_RWB, S_BRANCH, S_ILLEGAL: state_d = S_FETCH;
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // IDLE decodes to an all-zero control word, so async reset clears outputs too
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign InstrDone   = ctrl.instr_done;
  assign IllegalOp   = ctrl.illegal_op;
  assign State       = state_q;

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock, rising-edge active.
REQ-002 SHALL have port Reset, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have port Opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-004 SHALL have port MemReady, input, 1, block memory access complete this cycle.
REQ-005 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite and ALUSrcA, each 1 bit, with standard multicycle MIPS meanings.
REQ-006 SHALL have outputs ALUSrcB, ALUOp and PCSource, each 2 bits: ALUOp 00 add, 01 sub, 10 funct; PCSource 00 ALU, 01 ALUOut, 10 jump target.
REQ-007 SHALL have output State, 4 bits, the current FSM state for debug.
REQ-008 SHALL have output InstrDone, 1 bit, a one-cycle pulse on the final cycle of each instruction.
REQ-009 SHALL have output IllegalOp, 1 bit, a one-cycle pulse on decode of an unsupported opcode.

Function
REQ-010 SHALL implement a Moore FSM with states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP and ILLEGAL.
REQ-011 SHALL go IDLE->FETCH on the first clock edge after Reset deasserts.
REQ-012 In FETCH, SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCWrite SHALL be 1 only in cycles with MemReady=1.
REQ-013 SHALL hold FETCH while MemReady=0 and go to DECODE when MemReady=1, with zero wait states giving a minimum one cycle.
REQ-014 In DECODE, SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-015 From DECODE, SHALL branch on Opcode: 0->EXEC, 35 or 43->MEMADR, 4->BRANCH, 2->JUMP (REQ-027), any other->ILLEGAL.
REQ-016 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD if Opcode=35, else MEMWR.
REQ-017 MEMRD SHALL drive MemRead=1, IorD=1, hold while MemReady=0, and go to MEMWB on MemReady=1.
REQ-018 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-019 MEMWR SHALL drive MemWrite=1, IorD=1, hold while MemReady=0, and go to FETCH on MemReady=1.
REQ-020 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10 and go to RWB; RWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0 and go to FETCH.
REQ-021 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-022 ILLEGAL SHALL assert IllegalOp for one cycle with no PC, register or memory write, then go to FETCH.
REQ-023 InstrDone SHALL pulse in the last cycle of MEMWB, RWB, BRANCH, JUMP, ILLEGAL, and of MEMWR when MemReady=1.
REQ-024 Any output not listed for a state SHALL be 0; no output SHALL depend on Opcode except the next-state logic.
REQ-025 Minimum latencies with zero wait: R-type 4, lw 5, sw 4, beq 3, j 3 cycles.

Reset
REQ-026 While Reset=0, SHALL force State=IDLE and all outputs 0 asynchronously, including mid-FETCH and mid-MEMWR; no partial write SHALL be completed.

Configuration
REQ-027 With MIPS_CTRL_JUMP_EN defined, SHALL decode Opcode 2 to JUMP, which drives PCWrite=1, PCSource=10, then goes to FETCH; without it, JUMP is absent and Opcode 2 SHALL go to ILLEGAL.

Structure
REQ-028 SHALL take state encodings, opcode constants (R=0, J=2, BEQ=4, LW=35, SW=43), and ALUOp and PCSource codes from shared package mips_ctrl_pkg.
REQ-029 SHALL place per-state output decode in one combinational sub-module, mips_ctrl_outdec; the state register and next-state logic stay in the top module.

Verification
REQ-030 Reset low mid-MEMWR with MemReady=0 -> all outputs 0 and State=IDLE immediately; FETCH one cycle after release.
REQ-031 Opcode=35, MemReady=1 always -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 in cycle 5; InstrDone in cycle 5.
REQ-032 Opcode=43, MemReady low 3 cycles in MEMWR -> MemWrite held 4 cycles; InstrDone only in the MemReady=1 cycle.
REQ-033 Opcode=0 with FETCH MemReady delayed 2 cycles -> IRWrite and PCWrite high only in the third FETCH cycle; RWB has RegDst=1.
REQ-034 Opcode=4 -> BRANCH has PCWriteCond=1, ALUOp=01, PCSource=01; 3 cycles total.
REQ-035 Opcode=2 with and without MIPS_CTRL_JUMP_EN -> JUMP with PCWrite=1 and PCSource=10, versus ILLEGAL with an IllegalOp pulse and no writes.
